// File: rtl/add_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract controller.
package add_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign, sum does not.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/simple_8bit_adder.sv
// Combinational 8-bit ripple adder slice shared by all byte positions.
module simple_8bit_adder
  import add_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] c;

  // Bit-level ripple: each stage consumes the carry of the stage below.
  always_comb begin
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[BYTE_W];
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial W-bit add/subtract: one shared 8-bit adder walks the operands
// LSB byte first, carrying between slices in a register.
//
// state | meaning
// IDLE  | ready for a request; operands latched on in_valid
// RUN   | one byte slice per cycle, LSB first, NBYTES cycles
// DONE  | result/cout/ovf presented until the consumer takes it
module byte_serial_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] op_a,
  input  logic [BYTE_W*NBYTES-1:0] op_b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = $clog2(NBYTES) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [BYTE_W-1:0] add_sum;
  logic            add_cout;
  logic            accept;
  logic            last_byte;
  logic [W+BYTE_W-1:0] res_cat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_byte = (state == RUN) && (idx == LAST_IDX);

  // New slice enters from the MSB side so byte 0 ends up at the bottom.
  assign res_cat = {add_sum, result};

  simple_8bit_adder u_adder (
    .a    (a_reg[BYTE_W-1:0]),
    .b    (b_reg[BYTE_W-1:0]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: requests only taken in IDLE, results held until handoff.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)  state_nxt = RUN;
      RUN:  if (last_byte) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Operand latch, byte shifting, carry chaining and final flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      // Subtract as A + ~B + ~borrow_in.
      a_reg <= op_a;
      b_reg <= sub ? ~op_b : op_b;
      carry <= cin ^ sub;
      idx   <= '0;
    end else if (state == RUN) begin
      a_reg  <= a_reg >> BYTE_W;
      b_reg  <= b_reg >> BYTE_W;
      result <= res_cat[W+BYTE_W-1:BYTE_W];
      carry  <= add_cout;
      idx    <= idx + 1'b1;
      if (last_byte) begin
        cout <= add_cout;
        ovf  <= signed_ovf(a_reg[BYTE_W-1], b_reg[BYTE_W-1], add_sum[BYTE_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Scoreboard bench for byte_serial_add_ctrl with NBYTES=4.
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_miscmp = 0;
  int   cyc      = 0;
  int   t_acc    = 0;

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic written from the signed/unsigned definitions.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    exp_t        e;
    logic [W:0]  full;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.r  = full[W-1:0];
      e.c  = full[W];
      e.v  = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
      e.r  = full[W-1:0];
      e.c  = ~full[W];
      e.v  = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    end
    return e;
  endfunction

  // Present a request and return just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    sb.push_back(model(a, b, c, s));
    in_valid = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Wait for the result, compare against the scoreboard, stall, then hand off.
  task automatic recv(input int hold);
    exp_t e;
    int   n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("out_valid_wait", out_valid, 1'b1);
    chk("latency", 64'(cyc - t_acc), 64'(NB));
    if (sb.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk("result", result, e.r);
      chk("cout", cout, e.c);
      chk("ovf", ovf, e.v);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_result", result, e.r);
        chk("hold_in_ready", in_ready, 1'b0);
        chk("hold_out_valid", out_valid, 1'b1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    exp_t stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_cout_ovf", {cout, ovf}, 2'b00);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed cases
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); recv(0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); recv(0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1); recv(0);
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1); recv(0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); recv(0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1); recv(0);
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0); recv(0);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1); recv(0);

    // Back-pressure with a second request waiting
    send(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);
    sb.push_back(model(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1));
    in_valid = 1'b1; op_a = 32'h0000_0010; op_b = 32'h0000_0003; cin = 1'b1; sub = 1'b1;
    recv(5);
    chk("bubble_in_ready", in_ready, 1'b1);
    chk("bubble_busy", busy, 1'b0);
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    chk("second_taken_busy", busy, 1'b1);
    recv(0);

    // Reset in the second RUN cycle, after an op leaving cout/ovf set
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0); recv(0);
    send(32'hAAAA_5555, 32'h1111_2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_result", result, '0);
    chk("mid_rst_cout_ovf", {cout, ovf}, 2'b00);
    stale = sb.pop_back();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_out_valid", out_valid, 1'b0);
    end
    chk("post_rst_in_ready", in_ready, 1'b1);
    send(32'h0102_0304, 32'h1020_3040, 1'b1, 1'b0); recv(0);

    // Random mix, with out_ready pulsed while idle
    for (int k = 0; k < 12; k++) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      out_ready = 1'b0;
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
      recv(int'($urandom_range(0, 2)));
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
